// File: rtl/seq_pattern_tx_if.sv
// Bundles the request/serial-output signals of seq_pattern_tx.
// The master drives requests and the slave (the transmitter) drives the serial stream.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 16
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat_data;
  logic [4:0]       pat_len;
  logic [3:0]       rep_cnt;
  logic             dout;
  logic             bit_tick;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pat_data, pat_len, rep_cnt,
    input  dout, bit_tick, busy, done
  );

  modport slave (
    input  start, abort, pat_data, pat_len, rep_cnt,
    output dout, bit_tick, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured bit pattern MSB-first,
// TICK_DIV clocks per bit, repeated rep_cnt+1 times, then pulses done.
module seq_pattern_tx #(
  parameter int TICK_DIV = 2_500_000,
  parameter int PAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_pattern_tx_if.slave   bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = $clog2(PAT_W);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_SEND = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [4:0]       bit_q, bit_d;    // bits already finished in this repetition
  logic [3:0]       rep_q, rep_d;    // repetitions still to go after the current one
  logic [4:0]       len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             dout_q, dout_d;

  logic [4:0]    len_in;
  logic [IW-1:0] acc_idx, nxt_idx, rst_idx;
  logic          tick_end;

  assign tick_end = (state_q == S_SEND) && (tick_q == TICK_LAST);

  always_comb begin
    len_in = bus.pat_len;
    if (int'(bus.pat_len) > PAT_W) len_in = 5'(PAT_W);
    acc_idx = IW'(len_in - 5'd1);
    nxt_idx = IW'(len_q - 5'd2 - bit_q);
    rst_idx = IW'(len_q - 5'd1);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    len_d   = len_q;
    pat_d   = pat_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        dout_d = 1'b0;
        if (bus.start && !bus.abort && (len_in != 5'd0)) begin
          pat_d   = bus.pat_data;
          len_d   = len_in;
          rep_d   = bus.rep_cnt;
          bit_d   = 5'd0;
          dout_d  = bus.pat_data[acc_idx];
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          tick_d  = '0;
          bit_d   = 5'd0;
          dout_d  = 1'b0;
        end else if (tick_end) begin
          tick_d = '0;
          if (bit_q == len_q - 5'd1) begin
            bit_d = 5'd0;
            if (rep_q == 4'd0) begin
              state_d = S_DONE;
              dout_d  = 1'b0;
            end else begin
              // Next repetition starts on this edge: no idle bit between repeats.
              rep_d  = rep_q - 4'd1;
              dout_d = pat_q[rst_idx];
            end
          end else begin
            bit_d  = bit_q + 5'd1;
            dout_d = pat_q[nxt_idx];
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tick_d  = '0;
        dout_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        bit_d   = 5'd0;
        dout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= 5'd0;
      rep_q   <= 4'd0;
      len_q   <= 5'd0;
      pat_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      dout_q  <= dout_d;
    end
  end

  // Status outputs decode straight from state so reset clears them immediately.
  assign bus.dout     = dout_q;
  assign bus.bit_tick = tick_end;
  assign bus.busy     = (state_q == S_SEND);
  assign bus.done     = (state_q == S_DONE);
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx with TICK_DIV=4: a per-cycle expected-output queue model,
// directed literal checks of key scenarios, then randomized traffic.
module tb_seq_pattern_tx;
  localparam int TD    = 4;
  localparam int PAT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W)) bus ();

  seq_pattern_tx #(.TICK_DIV(TD), .PAT_W(PAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int fail_prints = 0;

  typedef struct packed {
    logic busy;
    logic dout;
    logic tick;
    logic done;
  } exp_t;

  exp_t exp_q[$];

  // Model: every accepted request expands into its full per-cycle output waveform.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (bus.start && !bus.abort && bus.pat_len != 5'd0) begin
        int len_e;
        logic [PAT_W-1:0] d;
        len_e = (bus.pat_len > 5'd16) ? 16 : int'(bus.pat_len);
        d = bus.pat_data;
        for (int r = 0; r <= int'(bus.rep_cnt); r++)
          for (int i = len_e - 1; i >= 0; i--)
            for (int t = 0; t < TD; t++)
              exp_q.push_back({1'b1, d[i], (t == TD - 1), 1'b0});
        exp_q.push_back(4'b0001);
      end
    end else begin
      exp_t cur;
      cur = exp_q.pop_front();
      if (cur.busy && bus.abort) exp_q.delete();
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      exp_t e;
      exp_t a;
      e = (exp_q.size() == 0) ? 4'b0000 : exp_q[0];
      a = {bus.busy, bus.dout, bus.bit_tick, bus.done};
      total++;
      if (a !== e) begin
        bad++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL cycle_cmp t=%0t busy/dout/tick/done got=%b want=%b", $time, a, e);
        end
      end
    end
  end

  // Bit-rate "1101" detector fed from the serial output.
  logic [3:0] det_sh;
  int         det_cnt;
  logic       det_clr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_sh  <= 4'd0;
      det_cnt <= 0;
    end else if (det_clr) begin
      det_sh  <= 4'd0;
      det_cnt <= 0;
    end else if (bus.bit_tick) begin
      det_sh <= {det_sh[2:0], bus.dout};
      if ({det_sh[2:0], bus.dout} == 4'b1101) det_cnt <= det_cnt + 1;
    end
  end

  logic rec_busy [1:80];
  logic rec_dout [1:80];
  logic rec_tick [1:80];
  logic rec_done [1:80];
  int busy_cnt, tick_cnt, done_cnt, done_cyc;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Called right after a negedge; start is seen at the next posedge (the accept edge).
  task automatic send(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r);
    bus.pat_data = d;
    bus.pat_len  = l;
    bus.rep_cnt  = r;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.pat_data = 16'($urandom);
    bus.pat_len  = 5'($urandom);
    bus.rep_cnt  = 4'($urandom);
  endtask

  // Samples cycles 1..n after the accept edge; optional extra start/abort in given cycles.
  task automatic record(input int n, input int restart_at, input int abort_at, input int start_at);
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      rec_busy[c] = bus.busy;
      rec_dout[c] = bus.dout;
      rec_tick[c] = bus.bit_tick;
      rec_done[c] = bus.done;
      bus.start = (c == restart_at) || (c == start_at);
      bus.abort = (c == abort_at);
      if (c == restart_at) begin
        bus.pat_data = 16'($urandom);
        bus.pat_len  = 5'($urandom_range(1, 16));
        bus.rep_cnt  = 4'($urandom_range(0, 3));
      end
      if (c == start_at) begin
        bus.pat_data = 16'h000D;
        bus.pat_len  = 5'd4;
        bus.rep_cnt  = 4'd0;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic tally(input int n);
    busy_cnt = 0; tick_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= n; c++) begin
      busy_cnt += int'(rec_busy[c]);
      tick_cnt += int'(rec_tick[c]);
      if (rec_done[c]) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
  endtask

  function automatic logic [31:0] bits(input int first, input int step, input int count);
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < count; k++) acc = {acc[30:0], rec_dout[first + k * step]};
    return acc;
  endfunction

  task automatic check_basic(input string tag);
    tally(18);
    check({tag, "_busy_cycles"}, busy_cnt, 16);
    check({tag, "_ticks"}, tick_cnt, 4);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_cyc, 17);
    check({tag, "_dout_wave"}, bits(1, 1, 16), 32'h0000FF0F);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((bus.busy || bus.done || exp_q.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", (k < bound), 1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    det_clr = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pat_data = '0; bus.pat_len = '0; bus.rep_cnt = '0;
    #1;
    @(negedge clk);
    check("reset_outputs", {bus.busy, bus.dout, bus.bit_tick, bus.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 1101 pattern, plus an ignored second start in the middle of it.
    send(16'h000D, 5'd4, 4'd0);
    record(18, 0, 0, 0);
    check_basic("basic");
    wait_idle(50);
    send(16'h000D, 5'd4, 4'd0);
    record(18, 5, 0, 0);
    check_basic("overlap");
    wait_idle(50);

    // Repeat without gap.
    send(16'h0002, 5'd2, 4'd2);
    record(26, 0, 0, 0);
    tally(26);
    check("repeat_busy_cycles", busy_cnt, 24);
    check("repeat_dout_wave", bits(1, 1, 24), 32'h00F0F0F0);
    check("repeat_done_count", done_cnt, 1);
    check("repeat_done_cycle", done_cyc, 25);
    wait_idle(50);

    // Zero length is ignored.
    send(16'hFFFF, 5'd0, 4'd3);
    record(6, 0, 0, 0);
    tally(6);
    check("len0_busy_cycles", busy_cnt, 0);

    // Length above PAT_W clamps to 16 bits.
    send(16'hABCD, 5'd20, 4'd0);
    record(66, 0, 0, 0);
    tally(66);
    check("clamp_busy_cycles", busy_cnt, 64);
    check("clamp_bits", bits(1, 4, 16), 32'h0000ABCD);
    wait_idle(50);

    // Abort in cycle 6, restart in cycle 7.
    send(16'h000D, 5'd4, 4'd0);
    record(18, 0, 6, 7);
    tally(18);
    check("abort_busy_before", rec_busy[6], 1);
    check("abort_busy_after", rec_busy[7], 0);
    check("abort_dout_after", rec_dout[7], 0);
    check("abort_no_done", done_cnt, 0);
    check("abort_restart_busy", rec_busy[8], 1);
    check("abort_restart_dout", rec_dout[8], 1);
    wait_idle(50);

    // Asynchronous reset in cycle 9.
    send(16'h000D, 5'd4, 4'd0);
    record(8, 0, 0, 0);
    check("rst_busy_before", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1 check("rst_outputs_zero", {bus.busy, bus.dout, bus.bit_tick, bus.done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h000D, 5'd4, 4'd0);
    record(18, 0, 0, 0);
    check_basic("post_rst");
    wait_idle(50);

    // Loopback into the detector.
    det_clr = 1'b1;
    @(negedge clk);
    det_clr = 1'b0;
    send(16'h000D, 5'd4, 4'd1);
    wait_idle(100);
    check("loopback_detects", det_cnt, 2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.abort    = ($urandom_range(0, 99) == 0);
      bus.pat_data = 16'($urandom);
      if ($urandom_range(0, 10) == 0)      bus.pat_len = 5'd0;
      else if ($urandom_range(0, 9) == 0)  bus.pat_len = 5'($urandom_range(17, 31));
      else                                 bus.pat_len = 5'($urandom_range(1, 16));
      bus.rep_cnt = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                                : 4'($urandom_range(0, 3));
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    wait_idle(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter TICK_DIV, default 2_500_000: clk cycles per transmitted bit; legal range 2..2^22.
REQ-002 Parameter PAT_W, default 16: maximum pattern length in bits.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to transmit a pattern; sampled every clk.
REQ-006 abort  input  1  synchronous cancel of the transfer in progress.
REQ-007 pat_data  input  PAT_W  pattern bits; only the pat_len LSBs are used.
REQ-008 pat_len  input  5  pattern length in bits; 0 is illegal.
REQ-009 rep_cnt  input  4  repetitions minus one; 0 = send once, 15 = send 16 times.
REQ-010 dout  output  1  serial bit stream, registered.
REQ-011 bit_tick  output  1  one-clk pulse on the last cycle of each bit period.
REQ-012 busy  output  1  high while a transfer is active.
REQ-013 done  output  1  one-clk pulse after the final bit of the final repetition.

Function
REQ-014 States SHALL be IDLE, SEND and DONE, one-hot encoded.
REQ-015 In IDLE, start=1 with pat_len!=0 and abort=0 SHALL accept a request:
- capture pat_data, pat_len and rep_cnt into internal registers;
- clear the bit counter and tick counter;
- enter SEND on the next edge.
REQ-016 In IDLE, start=1 with pat_len==0 SHALL be ignored; state stays IDLE.
REQ-017 pat_len>PAT_W SHALL be clamped to PAT_W at capture.
REQ-018 start asserted outside IDLE SHALL be ignored; inputs changing after capture SHALL NOT affect the transfer.
REQ-019 Bit order: MSB-first within the captured length, i.e. bit pat_len-1 first, bit 0 last. Example: pat_data=4'b1101, pat_len=4 sends 1,1,0,1.
REQ-020 dout SHALL present the first bit in the cycle SEND is entered (one cycle after the accepting edge).
REQ-021 Bit timing in SEND:
- the tick counter runs 0..TICK_DIV-1 and wraps to 0;
- each bit is held exactly TICK_DIV clk cycles;
- bit_tick=1 when count==TICK_DIV-1;
- dout changes only on the edge following bit_tick.
REQ-022 Sequencing on bit_tick:
- if the last bit of a repetition has been sent and repetitions remain, restart at bit pat_len-1 with no gap cycle;
- after the last bit of the last repetition, enter DONE.
REQ-023 A transfer SHALL last exactly pat_len*(rep_cnt+1)*TICK_DIV cycles in SEND.
REQ-024 DONE SHALL last one cycle with done=1, busy=0, dout=0, then return to IDLE; start in DONE is ignored.
REQ-025 busy SHALL be 1 in SEND and 0 in IDLE and DONE.
REQ-026 abort=1 in SEND SHALL return to IDLE on the next edge:
- dout=0, bit_tick=0, done not pulsed.
REQ-027 start and abort both high in IDLE: abort SHALL win and no request is accepted.
REQ-028 abort coinciding with the final bit_tick SHALL win: no done pulse.
REQ-029 In IDLE the tick counter SHALL hold 0 and dout=0.

Reset
REQ-030 rst_n low, at any time including mid-transfer, SHALL asynchronously force:
- state=IDLE; dout=0, bit_tick=0, busy=0, done=0;
- all counters and captured registers = 0.
REQ-031 After reset release, the first accept SHALL need only a start pulse; no warm-up cycles are required.

Verification (bench uses TICK_DIV=4)
REQ-032 Basic pattern: pat_data=16'h000D, pat_len=4, rep_cnt=0, 1-clk start ->
- busy high for 16 cycles; dout=1,1,0,1 with each bit held 4 cycles;
- 4 bit_tick pulses; done pulse at cycle 17 after the accept edge.
REQ-033 Repeat: pat_data=2'b10, pat_len=2, rep_cnt=2 ->
- dout=1,0,1,0,1,0 over 24 cycles with no gap cycle;
- exactly one done pulse.
REQ-034 Illegal and overlapping requests:
- start with pat_len=0 -> no busy;
- second start during SEND -> ignored; transfer length unchanged.
REQ-035 Abort: abort at cycle 6 of a 16-cycle transfer -> busy=0 and dout=0 next cycle; no done; a new start is accepted next cycle.
REQ-036 Reset mid-transfer: rst_n low at cycle 9 -> all outputs 0 immediately; after release, start gives a full correct transfer.
REQ-037 Loopback: dout into a matching bit-rate "1101" detector with pattern 1101 rep_cnt=1 -> detector fires once per repetition.
